jk_mod_counter: RTL and testbench



---
 rtl/jk_mod_counter.sv | 152 +++++++++++++++
 tb/tb_jk_mod_counter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - WIDTH-bit modulo up/down/load counter built from JK cells
//
// Purpose:
//   Synchronous modulo counter (count range 0..MODULUS-1) whose state bits are
//   individual JK flip-flop cells. A vector next-state value is computed
//   combinationally and then translated into per-bit J/K drives.
//
// Optional feature:
//   JKCNT_SATURATE_EN - when defined, up at MODULUS-1 and down at 0 saturate
//   instead of wrapping; the wrap flag still records the event.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (q=0, wrap=0)
//   en       in   1      count/load enable; low holds state
//   mode     in   2      00 hold, 01 up, 10 down, 11 load
//   load_val in   WIDTH  parallel load value (clamped to MODULUS-1)
//   q        out  WIDTH  counter state (registered)
//   tc       out  1      terminal count (combinational, for cascading)
//   wrap     out  1      sticky wrap/saturation flag (registered)

module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= (j & ~r_q) | (~k & r_q);
    end
  end

  assign q = r_q;

endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // MODULUS may equal 2**WIDTH, which does not fit in WIDTH bits, so all
  // range checks are done against the largest legal state instead.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

`ifdef JKCNT_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_END_VAL = MAX_VAL;
  localparam logic [WIDTH-1:0] DN_END_VAL = '0;
`else
  localparam logic [WIDTH-1:0] UP_END_VAL = '0;
  localparam logic [WIDTH-1:0] DN_END_VAL = MAX_VAL;
`endif

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_eff;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_wrap_next;
  logic             r_wrap;

  always_comb begin
    w_next      = w_q;
    w_wrap_next = r_wrap;
    // An out-of-range state counts as MAX_VAL so up/down always land in range.
    w_q_eff     = (w_q > MAX_VAL) ? MAX_VAL : w_q;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (w_q_eff == MAX_VAL) begin
            w_next      = UP_END_VAL;
            w_wrap_next = 1'b1;
          end else begin
            w_next = w_q_eff + ONE;
          end
        end
        MODE_DN: begin
          if (w_q_eff == '0) begin
            w_next      = DN_END_VAL;
            w_wrap_next = 1'b1;
          end else begin
            w_next = w_q_eff - ONE;
          end
        end
        MODE_LOAD: begin
          // load_val is only looked at here, so it cannot disturb other modes.
          w_next      = (load_val > MAX_VAL) ? MAX_VAL : load_val;
          w_wrap_next = 1'b0;
        end
        MODE_HOLD: begin
          w_next = w_q;
        end
        default: begin
          w_next = w_q;
        end
      endcase
    end
  end

  // Set only bits that must rise, reset only bits that must fall.
  assign w_j = ~w_q & w_next;
  assign w_k = w_q & ~w_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (w_j[gi]),
        .k   (w_k[gi]),
        .q   (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = w_q;
  assign wrap = r_wrap;
  assign tc   = en & (((mode == MODE_UP) & (w_q == MAX_VAL)) |
                      ((mode == MODE_DN) & (w_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - scoreboard bench for jk_mod_counter (MODULUS 10 and 16)

module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  typedef struct {
    int tc_a; int q_a; int w_a;
    int tc_b; int q_b; int w_b;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mq_a = 0, mw_a = 0, mq_b = 0, mw_b = 0;
  bit   sat;

  // Reference model: plain integer arithmetic on the counting rules.
  function automatic void model(input int m_mod, input bit r, input bit e,
                                input int m, input int lv,
                                inout int qv, inout int wv, output int tcv);
    int qq;
    tcv = (e && ((m == 1 && qv == m_mod - 1) || (m == 2 && qv == 0))) ? 1 : 0;
    if (r) begin
      qv = 0;
      wv = 0;
    end else if (e) begin
      qq = (qv >= m_mod) ? m_mod - 1 : qv;
      if (m == 1) begin
        if (qq == m_mod - 1) begin
          qv = sat ? m_mod - 1 : 0;
          wv = 1;
        end else qv = qq + 1;
      end else if (m == 2) begin
        if (qq == 0) begin
          qv = sat ? 0 : m_mod - 1;
          wv = 1;
        end else qv = qq - 1;
      end else if (m == 3) begin
        qv = (lv < m_mod) ? lv : m_mod - 1;
        wv = 0;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input int m, input int lv);
    exp_t x;
    @(negedge clk);
    #1;
    rst      = r;
    en       = e;
    mode     = 2'(m);
    load_val = 4'(lv);
    model(10, r, e, m, lv, mq_a, mw_a, x.tc_a);
    model(16, r, e, m, lv, mq_b, mw_b, x.tc_b);
    x.q_a = mq_a; x.w_a = mw_a;
    x.q_b = mq_b; x.w_b = mw_b;
    sb.push_back(x);
  endtask

  // Monitor: tc is checked with inputs settled before the edge, q/wrap after it.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("tc_a", int'(tc_a), x.tc_a);
        check("tc_b", int'(tc_b), x.tc_b);
        @(posedge clk);
        #1;
        check("q_a", int'(q_a), x.q_a);
        check("wrap_a", int'(wrap_a), x.w_a);
        check("q_b", int'(q_b), x.q_b);
        check("wrap_b", int'(wrap_b), x.w_b);
      end
    end
  end

  initial begin
`ifdef JKCNT_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    rst = 1'b1; en = 1'b0; mode = 2'b00; load_val = 4'd0;

    step(1, 0, 0, 0);
    repeat (12) step(0, 1, 1, 0);
    step(0, 1, 3, 7);
    repeat (9) step(0, 1, 2, 0);
    step(0, 1, 3, 13);
    repeat (3) step(0, 0, 1, 0);
    step(0, 1, 3, 4);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    repeat (2) step(0, 1, 1, 0);
    step(0, 1, 3, 15);
    repeat (2) step(0, 1, 1, 0);
    step(0, 1, 3, 8);
    repeat (3) step(0, 1, 1, 0);
    step(0, 1, 3, 0);
    repeat (2) step(0, 1, 2, 0);
    step(0, 1, 0, 5);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
